// File: rtl/stream_delay_line.sv
// Runtime-programmable circular-RAM delay line for avln_st streams, with priming.
// Optional DELAY_LINE_PKT_GATE_EN: hold output until the first emitted sop.
package stream_delay_line_pkg;
  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
    logic        valid;
  } avln_st_t;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
  } line_t;
endpackage

module stream_delay_line
  import stream_delay_line_pkg::*;
#(
  parameter int ADDR_W        = 10,
  parameter int DEFAULT_DELAY = 16
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  avln_st_t          in,
  output avln_st_t          out,
  input  logic [ADDR_W-1:0] delay_cfg,
  input  logic              cfg_load,
  output logic [ADDR_W-1:0] fill_count,
  output logic              primed
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  line_t mem [DEPTH];

  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] fill_q, fill_d;
  logic [ADDR_W-1:0] dly_q, dly_d;
  logic [ADDR_W-1:0] rd_addr;
  avln_st_t          out_q, out_d;
  line_t             in_line, rd_line, emit_line;
  logic              emit, show;
`ifdef DELAY_LINE_PKT_GATE_EN
  logic              gate_q, gate_d;
`endif

  always_comb begin
    in_line   = line_t'{in.data, in.sop, in.eop, in.empty};
    rd_addr   = wptr_q - dly_q;
    rd_line   = mem[rd_addr];
    // D=0 must bypass: the RAM word at wptr is the one being written now
    emit_line = (dly_q == '0) ? in_line : rd_line;
    emit      = in.valid && !cfg_load && (fill_q == dly_q);
`ifdef DELAY_LINE_PKT_GATE_EN
    show   = emit && (gate_q || emit_line.sop);
    gate_d = gate_q;
    if (cfg_load) gate_d = 1'b0;
    else if (show) gate_d = 1'b1;
`else
    show   = emit;
`endif
    wptr_d = in.valid ? wptr_q + ONE : wptr_q;
    fill_d = fill_q;
    dly_d  = dly_q;
    if (cfg_load) begin
      dly_d  = delay_cfg;
      fill_d = in.valid ? ONE : '0;
    end else if (in.valid && !emit) begin
      fill_d = fill_q + ONE;
    end
    out_d       = out_q;
    out_d.valid = show;
    out_d.sop   = 1'b0;
    out_d.eop   = 1'b0;
    if (show) begin
      out_d.data  = emit_line.data;
      out_d.sop   = emit_line.sop;
      out_d.eop   = emit_line.eop;
      out_d.empty = emit_line.empty;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (in.valid) mem[wptr_q] <= in_line;
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      fill_q <= '0;
      dly_q  <= ADDR_W'(DEFAULT_DELAY);
      out_q  <= '0;
`ifdef DELAY_LINE_PKT_GATE_EN
      gate_q <= 1'b0;
`endif
    end else begin
      wptr_q <= wptr_d;
      fill_q <= fill_d;
      dly_q  <= dly_d;
      out_q  <= out_d;
`ifdef DELAY_LINE_PKT_GATE_EN
      gate_q <= gate_d;
`endif
    end
  end

  assign out        = out_q;
  assign fill_count = fill_q;
  assign primed     = (fill_q == dly_q);

endmodule

// File: tb/tb_stream_delay_line.sv
// Directed bench for stream_delay_line with a history model and expected-output queue.
module tb_stream_delay_line;
  import stream_delay_line_pkg::*;

  localparam int AW = 5;

  logic          sys_clk = 1'b0;
  logic          reset   = 1'b1;
  avln_st_t      in_s;
  avln_st_t      out_s;
  logic [AW-1:0] delay_cfg;
  logic          cfg_load;
  logic [AW-1:0] fill_count;
  logic          primed;

  always #5 sys_clk = ~sys_clk;

  stream_delay_line #(.ADDR_W(AW), .DEFAULT_DELAY(16)) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .in         (in_s),
    .out        (out_s),
    .delay_cfg  (delay_cfg),
    .cfg_load   (cfg_load),
    .fill_count (fill_count),
    .primed     (primed)
  );

  int       n_vec = 0;
  int       n_err = 0;
  int       m_d;
  int       m_fill;
  bit       m_gate;
  line_t    hist[$];
  avln_st_t sb[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_d    = 16;
    m_fill = 0;
    m_gate = 1'b0;
    hist.delete();
    sb.delete();
  endtask

  task automatic cyc(input bit v, input logic [31:0] d, input bit s, input bit e,
                     input logic [1:0] em, input bit ld, input logic [AW-1:0] cfg);
    avln_st_t x;
    line_t    l;
    bit       emit;
    bit       show;
    l.data = d; l.sop = s; l.eop = e; l.empty = em;
    in_s.data = d; in_s.sop = s; in_s.eop = e; in_s.empty = em; in_s.valid = v;
    cfg_load  = ld;
    delay_cfg = cfg;
    x = '0;
    if (v) hist.push_back(l);
    emit = v && !ld && (m_fill == m_d);
    show = emit;
`ifdef DELAY_LINE_PKT_GATE_EN
    if (emit) show = m_gate || hist[hist.size()-1-m_d].sop;
    if (ld) m_gate = 1'b0;
    else if (show) m_gate = 1'b1;
`endif
    if (show) begin
      x.valid = 1'b1;
      x.data  = hist[hist.size()-1-m_d].data;
      x.sop   = hist[hist.size()-1-m_d].sop;
      x.eop   = hist[hist.size()-1-m_d].eop;
      x.empty = hist[hist.size()-1-m_d].empty;
    end
    if (v && !ld && !emit) m_fill++;
    if (ld) begin
      m_d    = int'(cfg);
      m_fill = v ? 1 : 0;
    end
    sb.push_back(x);
    @(posedge sys_clk);
    #1;
    x = sb.pop_front();
    chk("out_valid", out_s.valid, x.valid);
    chk("out_sop", out_s.sop, x.sop);
    chk("out_eop", out_s.eop, x.eop);
    if (x.valid) begin
      chk("out_data", out_s.data, x.data);
      chk("out_empty", out_s.empty, x.empty);
    end
    chk("fill_count", fill_count, m_fill);
    chk("primed", primed, m_fill == m_d);
  endtask

  initial begin
    in_s      = '0;
    cfg_load  = 1'b0;
    delay_cfg = '0;
    reset     = 1'b1;
    model_reset();
    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst_valid", out_s.valid, 1'b0);
    chk("rst_data", out_s.data, 32'h0);
    chk("rst_fill", fill_count, 0);
    chk("rst_primed", primed, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 40; i++)
      cyc(1'b1, 32'(i), (i % 10) == 0, (i % 10) == 9, 2'(i), 1'b0, '0);

    cyc(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1, 5'd0);
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 32'hA0 + 32'(i), i == 0, i == 7, 2'd1, 1'b0, '0);

    cyc(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1, 5'd31);
    for (int i = 0; i < 200; i++)
      cyc((i % 2) == 0, 32'h100 + 32'(i), (i % 20) == 0, (i % 20) == 18,
          2'(i >> 1), 1'b0, '0);

    cyc(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1, 5'd8);
    for (int i = 0; i < 20; i++)
      cyc(1'b1, 32'h300 + 32'(i), (i % 5) == 0, (i % 5) == 4, 2'(i), 1'b0, '0);
    cyc(1'b1, 32'h3FF, 1'b1, 1'b0, 2'd3, 1'b1, 5'd3);
    for (int i = 0; i < 10; i++)
      cyc(1'b1, 32'h400 + 32'(i), 1'b0, i == 9, 2'd2, 1'b0, '0);

    cyc(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1, 5'd4);
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 32'h500 + 32'(i), i == 0, 1'b0, 2'd0, 1'b0, '0);
    in_s = '0;
    cfg_load = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    chk("arst_valid", out_s.valid, 1'b0);
    chk("arst_sop", out_s.sop, 1'b0);
    chk("arst_eop", out_s.eop, 1'b0);
    chk("arst_fill", fill_count, 0);
    @(posedge sys_clk);
    #1;
    reset = 1'b0;
    model_reset();
    chk("arst_primed", primed, 1'b0);
    for (int i = 0; i < 20; i++)
      cyc(1'b1, 32'h600 + 32'(i), (i % 10) == 0, (i % 10) == 9, 2'd0, 1'b0, '0);

    cyc(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b1, 5'd4);
    for (int i = 0; i < 20; i++)
      cyc(1'b1, 32'h700 + 32'(i), i == 2 || i == 10, i == 9 || i == 17, 2'd1, 1'b0, '0);
    cyc(1'b1, 32'h7F0, 1'b1, 1'b0, 2'd0, 1'b1, 5'd4);
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 32'h800 + 32'(i), i == 4, i == 7, 2'd2, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
